// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: serial bitstream loader for the CLB configuration registers.
// Hunts for a sync byte, reads an 8-bit frame count, then deserialises one
// 37-bit word plus an even-parity bit per CLB and strobes it into CFG_*.
// Optional trailer check: define CLB_CFG_CRC_EN to append a CRC-8 (poly 0x07)
// over the count byte and all data fields, verified before DONE.
//
// Handshake: DIN is consumed only in cycles with DVALID=1; there is no
// backpressure. CFG_WE is a one-cycle strobe, qualified by nothing else, and
// CFG_ADDR/CFG_DATA hold their last written values between strobes.
module clb_cfg_loader #(
    parameter int          N_CLB  = 64,
    parameter int          ADDR_W = 6,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              K,
    input  logic              RST_N,
    input  logic              PROG,
    input  logic              DIN,
    input  logic              DVALID,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              CFG_WE,
    output logic [ADDR_W-1:0] CFG_ADDR,
    output logic [36:0]       CFG_DATA,
    output logic [2:0]        STATE_DBG
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_FRAME = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
`ifdef CLB_CFG_CRC_EN
    localparam logic [2:0] S_CRC   = 3'd4;
    localparam logic [2:0] S_AFTER = S_CRC;
`else
    localparam logic [2:0] S_AFTER = S_DONE;
`endif

    localparam logic [7:0] N_CLB_B = 8'(N_CLB);

    logic [2:0]        state_q, state_d;
    logic [36:0]       sr_q, sr_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic [7:0]        idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [36:0]       data_q, data_d;
    logic [37:0]       shifted;

    // The shift register with the incoming bit appended; a full frame is
    // 37 data bits followed by the parity bit in the LSB.
    assign shifted = {sr_q, DIN};

`ifdef CLB_CFG_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_fb;

    // CRC-8 over count bits and data bits only; parity bits are skipped.
    always_comb begin
        crc_d  = crc_q;
        crc_fb = crc_q[7] ^ DIN;
        if (PROG) begin
            crc_d = 8'h00;
        end else if (DVALID && (state_q == S_COUNT ||
                                (state_q == S_FRAME && bit_cnt_q < 6'd37))) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
        end
    end

    // CRC accumulator register.
    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) crc_q <= 8'h00;
        else        crc_q <= crc_d;
    end
`endif

    // Next-state logic; PROG overrides everything, including a completing frame.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        fcnt_d    = fcnt_q;
        idx_d     = idx_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        if (PROG) begin
            state_d   = S_SYNC;
            sr_d      = '0;
            bit_cnt_d = '0;
            fcnt_d    = '0;
            idx_d     = '0;
        end else if (DVALID) begin
            case (state_q)
                S_SYNC: begin
                    sr_d = shifted[36:0];
                    if (shifted[7:0] == SYNC) begin
                        state_d   = S_COUNT;
                        sr_d      = '0;
                        bit_cnt_d = '0;
                    end
                end
                S_COUNT: begin
                    if (bit_cnt_q == 6'd7) begin
                        fcnt_d    = shifted[7:0];
                        sr_d      = '0;
                        bit_cnt_d = '0;
                        idx_d     = '0;
                        if (shifted[7:0] == 8'd0)          state_d = S_AFTER;
                        else if (shifted[7:0] > N_CLB_B)   state_d = S_ERR;
                        else                               state_d = S_FRAME;
                    end else begin
                        sr_d      = shifted[36:0];
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                S_FRAME: begin
                    if (bit_cnt_q == 6'd37) begin
                        sr_d      = '0;
                        bit_cnt_d = '0;
                        if (^shifted == 1'b0) begin
                            we_d   = 1'b1;
                            addr_d = idx_q[ADDR_W-1:0];
                            data_d = shifted[37:1];
                            idx_d  = idx_q + 8'd1;
                            if (idx_q + 8'd1 == fcnt_q) state_d = S_AFTER;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        sr_d      = shifted[36:0];
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
`ifdef CLB_CFG_CRC_EN
                S_CRC: begin
                    if (bit_cnt_q == 6'd7) begin
                        sr_d      = '0;
                        bit_cnt_d = '0;
                        state_d   = (shifted[7:0] == crc_q) ? S_DONE : S_ERR;
                    end else begin
                        sr_d      = shifted[36:0];
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // State, counters, shift register and write port registers.
    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            fcnt_q    <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            fcnt_q    <= fcnt_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    // DONE/ERR are sticky by virtue of their states only leaving on PROG.
    assign BUSY      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign DONE      = (state_q == S_DONE);
    assign ERR       = (state_q == S_ERR);
    assign CFG_WE    = we_q;
    assign CFG_ADDR  = addr_q;
    assign CFG_DATA  = data_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Bench for clb_cfg_loader: directed bitstreams, write scoreboard, status checks.
module tb_clb_cfg_loader;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;

    logic        K = 1'b0;
    logic        RST_N = 1'b0;
    logic        PROG = 1'b0;
    logic        DIN = 1'b0;
    logic        DVALID = 1'b0;
    logic        BUSY, DONE, ERR, CFG_WE;
    logic [5:0]  CFG_ADDR;
    logic [36:0] CFG_DATA;
    logic [2:0]  STATE_DBG;

    logic [42:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tb_crc;

    clb_cfg_loader dut (
        .K(K), .RST_N(RST_N), .PROG(PROG), .DIN(DIN), .DVALID(DVALID),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CFG_WE(CFG_WE),
        .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .STATE_DBG(STATE_DBG)
    );

    // Clock and watchdog
    always #5 K = ~K;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge K) begin
        if (RST_N && CFG_WE) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         CFG_ADDR, CFG_DATA);
            end else begin
                logic [42:0] e;
                e = exp_q.pop_front();
                if ({CFG_ADDR, CFG_DATA} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             CFG_ADDR, CFG_DATA, e[42:37], e[36:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [63:0] v, input int n);
        logic fb;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[7] ^ v[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Driver tasks: all input changes happen on the falling edge.
    task automatic send_bit(input logic b, input bit gap);
        DIN = b;
        DVALID = 1'b1;
        @(negedge K);
        if (gap) begin
            DVALID = 1'b0;
            DIN = 1'($urandom_range(0, 1));
            @(negedge K);
        end
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic pulse_prog();
        PROG = 1'b1;
        DVALID = 1'b0;
        @(negedge K);
        PROG = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] fcnt, input bit noise);
        pulse_prog();
        if (noise) send_bits(64'h3C, 8, 1'b0);
        send_bits(64'hA5, 8, 1'b0);
        send_bits({56'b0, fcnt}, 8, 1'b0);
        tb_crc = crc_upd(8'h00, {56'b0, fcnt}, 8);
    endtask

    task automatic send_frame(input logic [36:0] d, input bit flip, input bit gap,
                              input bit expect_wr, input logic [5:0] addr);
        logic par;
        par = (^d) ^ flip;
        if (expect_wr) exp_q.push_back({addr, d});
        send_bits({25'b0, d, par}, 38, gap);
        tb_crc = crc_upd(tb_crc, {27'b0, d}, 37);
        DVALID = 1'b0;
    endtask

    task automatic finish_load(input bit bad_trailer);
`ifdef CLB_CFG_CRC_EN
        send_bits({56'b0, tb_crc ^ (bad_trailer ? 8'hFF : 8'h00)}, 8, 1'b0);
`else
        if (bad_trailer) DIN = 1'b0;
`endif
        DVALID = 1'b0;
    endtask

    task automatic wait_end(input string name, input logic exp_done, input logic exp_err);
        int t;
        t = 0;
        DVALID = 1'b0;
        while (!(DONE || ERR) && t < 100) begin
            @(negedge K);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no DONE/ERR in 100 cycles, required one", name);
        end
        repeat (3) @(negedge K);
        check({name, "_done"}, 64'(DONE), 64'(exp_done));
        check({name, "_err"}, 64'(ERR), 64'(exp_err));
        check({name, "_busy"}, 64'(BUSY), 64'd0);
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Directed test sequence
    initial begin
        repeat (3) @(negedge K);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_err", 64'(ERR), 64'd0);
        check("rst_we", 64'(CFG_WE), 64'd0);
        check("rst_state", 64'(STATE_DBG), 64'(ST_IDLE));
        RST_N = 1'b1;
        @(negedge K);

        // Two good frames after noise and sync
        pulse_prog();
        check("prog_busy", 64'(BUSY), 64'd1);
        start_load(8'h02, 1'b1);
        send_frame(37'h0_0000_0116, 1'b0, 1'b0, 1'b1, 6'd0);
        send_frame(37'h1F_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 6'd1);
        finish_load(1'b0);
        wait_end("two_frames", 1'b1, 1'b0);
        check("hold_addr", 64'(CFG_ADDR), 64'd1);
        check("hold_data", 64'(CFG_DATA), 64'h1F_FFFF_FFFF);

        // Asynchronous reset in the middle of a frame
        start_load(8'h01, 1'b0);
        send_bits(64'h3FF, 10, 1'b0);
        RST_N = 1'b0;
        #1;
        check("midrst_busy", 64'(BUSY), 64'd0);
        check("midrst_addr", 64'(CFG_ADDR), 64'd0);
        check("midrst_data", 64'(CFG_DATA), 64'd0);
        check("midrst_state", 64'(STATE_DBG), 64'(ST_IDLE));
        DVALID = 1'b0;
        @(negedge K);
        RST_N = 1'b1;
        @(negedge K);

        // Bad parity on the second frame
        start_load(8'h02, 1'b1);
        send_frame(37'h0_0000_0116, 1'b0, 1'b0, 1'b1, 6'd0);
        send_frame(37'h1F_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 6'd1);
        wait_end("bad_parity", 1'b0, 1'b1);

        // Frame count above the array size errors right after the count byte
        start_load(8'h41, 1'b0);
        DVALID = 1'b0;
        check("fcnt_hi_err", 64'(ERR), 64'd1);
        check("fcnt_hi_busy", 64'(BUSY), 64'd0);
        wait_end("fcnt_hi", 1'b0, 1'b1);

        // Maximum legal frame count is accepted (no immediate error)
        start_load(8'h40, 1'b0);
        DVALID = 1'b0;
        check("fcnt_max_busy", 64'(BUSY), 64'd1);
        check("fcnt_max_err", 64'(ERR), 64'd0);

        // Zero frames
        start_load(8'h00, 1'b0);
        finish_load(1'b0);
        wait_end("fcnt_zero", 1'b1, 1'b0);

        // Gap-free frame, then the same frame with DVALID toggling
        start_load(8'h01, 1'b0);
        send_frame(37'h15_A5A5_5A5A, 1'b0, 1'b0, 1'b1, 6'd0);
        finish_load(1'b0);
        wait_end("nogap", 1'b1, 1'b0);
        start_load(8'h01, 1'b0);
        send_frame(37'h15_A5A5_5A5A, 1'b0, 1'b1, 1'b1, 6'd0);
        finish_load(1'b0);
        wait_end("gaps", 1'b1, 1'b0);
        check("gaps_data", 64'(CFG_DATA), 64'h15_A5A5_5A5A);

        // Abort at bit 20 of frame 0, then a clean restart
        start_load(8'h01, 1'b0);
        send_bits(64'hFFFFF, 20, 1'b0);
        start_load(8'h01, 1'b0);
        send_frame(37'h0A_1234_5678, 1'b0, 1'b0, 1'b1, 6'd0);
        finish_load(1'b0);
        wait_end("abort_restart", 1'b1, 1'b0);

        // PROG in the same cycle as the parity bit: no write, back to SYNC
        start_load(8'h01, 1'b0);
        send_bits({27'b0, 37'h03_0F0F_0F0F}, 37, 1'b0);
        DIN = ^(37'h03_0F0F_0F0F);
        DVALID = 1'b1;
        PROG = 1'b1;
        @(negedge K);
        PROG = 1'b0;
        DVALID = 1'b0;
        repeat (2) @(negedge K);
        check("prog_win_state", 64'(STATE_DBG), 64'(ST_SYNC));
        check("prog_win_busy", 64'(BUSY), 64'd1);

`ifdef CLB_CFG_CRC_EN
        // Wrong CRC trailer
        start_load(8'h01, 1'b0);
        send_frame(37'h0A_1234_5678, 1'b0, 1'b0, 1'b1, 6'd0);
        finish_load(1'b1);
        wait_end("bad_crc", 1'b0, 1'b1);
`endif

        repeat (3) @(negedge K);
        check("final_pending", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
